// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, valid/ready on operands and result.
// Latency N cycles after acceptance (zero divisor: result visible the cycle after acceptance); result held until out_ready.
module seq_restoring_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q_sh;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  dvsr;
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic [N-1:0]  q_step;
  logic [N-1:0]  r_step;
  logic          accept;
  logic          last;

  // Restoring step; a restored remainder is below the divisor, so N bits suffice.
  always_comb begin
    shifted = {r_acc, q_sh[N-1]};
    trial   = shifted - {1'b0, dvsr};
    if (!trial[N]) begin
      r_step = trial[N-1:0];
      q_step = {q_sh[N-2:0], 1'b1};
    end else begin
      r_step = shifted[N-1:0];
      q_step = {q_sh[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    accept    = in_valid && (state == IDLE);
    last      = (cnt == CW'(N - 1));
    case (state)
      IDLE: if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      q_sh        <= '0;
      r_acc       <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              dvsr  <= divisor;
              q_sh  <= dividend;
              r_acc <= '0;
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          q_sh  <= q_step;
          r_acc <= r_step;
          cnt   <= cnt + CW'(1);
          if (last) begin
            quotient    <= q_step;
            remainder   <= r_step;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed cases plus a shuffled exhaustive sweep with random stalls,
// checked against plain / and % arithmetic.
module tb_seq_restoring_divider;
  localparam int N = 4;
  localparam int MAXV = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  seq_restoring_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain arithmetic, or the all-ones / dividend rule for a zero divisor.
  function automatic void ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin q = MAXV; r = a; z = 1; end
    else        begin q = a / b; r = a % b; z = 0; end
  endfunction

  task automatic garbage();
    in_valid = 1'($urandom);
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  // One operation. Latency is counted in edges after the acceptance edge:
  // N for a real division, 0 (visible straight after acceptance) for a zero divisor.
  task automatic do_op(input int a, input int b, input int stall, input bit noisy);
    int q, r, z, lat;
    ref_div(a, b, q, r, z);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    dividend = N'(a);
    divisor  = N'(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noisy) garbage();
      check("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, (b == 0) ? 0 : N);
    for (int s = 0; s <= stall; s++) begin
      if (noisy) garbage();
      check("quotient", quotient, q);
      check("remainder", remainder, r);
      check("div_by_zero", div_by_zero, z);
      check("out_valid_hold", out_valid, 1);
      check("in_ready_done", in_ready, 0);
      if (s < stall) begin
        @(posedge clk); #1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    check("quotient_kept", quotient, q);
  endtask

  int pairs[$];
  int idx, tmp, hits;

  initial begin
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(13, 4, 0, 0);
    do_op(15, 1, 0, 0);
    do_op(3, 9, 0, 0);
    do_op(0, 5, 0, 0);
    do_op(7, 0, 0, 0);
    do_op(14, 3, 6, 1);

    // No second acceptance from the noise driven while busy.
    for (int i = 0; i < 3; i++) begin
      check("no_extra_accept", out_valid, 0);
      @(posedge clk); #1;
    end

    // Reset in the middle of 11/2.
    in_valid = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_quotient", quotient, 0);
    check("arst_remainder", remainder, 0);
    check("arst_dbz", div_by_zero, 0);
    #4 rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk); #1;
      if (out_valid) hits++;
    end
    check("arst_no_out_valid", hits, 0);
    do_op(11, 2, 0, 0);

    // Exhaustive sweep in shuffled order with random stalls and busy-time noise.
    for (int i = 0; i <= MAXV; i++)
      for (int j = 0; j <= MAXV; j++)
        pairs.push_back((i << N) | j);
    for (int i = pairs.size() - 1; i > 0; i--) begin
      idx = $urandom_range(i, 0);
      tmp = pairs[i]; pairs[i] = pairs[idx]; pairs[idx] = tmp;
    end
    foreach (pairs[k]) begin
      do_op(pairs[k] >> N, pairs[k] & MAXV, $urandom_range(3, 0), 1);
      if ($urandom_range(3, 0) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
